// File: rtl/note_sequencer.sv
// Melody sequencer: fetches note entries from the song store,
// times notes and gaps, and drives a square wave to the speaker.
module note_sequencer #(
  parameter int TICK_DIV  = 1250000,
  parameter int GAP_TICKS = 2,
  parameter int ADDR_W    = 5
) (
  input  logic              CLOCK_50,
  input  logic              RESET_N,
  input  logic              start,
  input  logic              stop,
  input  logic              loop_en,
  output logic [ADDR_W-1:0] seq_addr,
  input  logic [7:0]        seq_data,
  output logic              busy,
  output logic [2:0]        note_code,
  output logic              done,
  output logic              speaker
);

  localparam int GW = (GAP_TICKS < 256) ? 8 : $clog2(GAP_TICKS + 1);
  localparam logic [27:0]   TICK_LAST = 28'(TICK_DIV - 1);
  localparam logic [GW-1:0] GAP_LOAD  = GW'(GAP_TICKS);
  localparam bit            HAS_GAP   = GAP_TICKS != 0;

  typedef enum logic [1:0] {IDLE, FETCH, TONE, GAP} state_t;

  state_t state_q, state_d;

  logic [27:0]       presc_q;
  logic [16:0]       tone_q;
  logic [16:0]       hp_q;
  logic [4:0]        dur_q;
  logic [GW-1:0]     gap_q;
  logic [ADDR_W-1:0] addr_d;
  logic [2:0]        code_d;
  logic              done_d;

  logic tick_end, tone_last, gap_last;
  logic is_end, half_end, rewind;
  logic stay_tone, stay_gap;

  function automatic logic [16:0] half_period(input logic [2:0] c);
    case (c)
      3'd1:    return 17'd95556;
      3'd2:    return 17'd85131;
      3'd3:    return 17'd75843;
      3'd4:    return 17'd71586;
      3'd5:    return 17'd63776;
      3'd6:    return 17'd56818;
      3'd7:    return 17'd47778;
      default: return 17'd0;
    endcase
  endfunction

  assign tick_end  = presc_q == TICK_LAST;
  assign tone_last = tick_end && dur_q == 5'd1;
  assign gap_last  = tick_end && gap_q == GW'(1);
  assign is_end    = seq_data[4:0] == 5'd0;
  assign half_end  = tone_q == hp_q - 17'd1;
  // a marker at address 0 never rewinds, so an empty song cannot spin
  assign rewind    = loop_en && seq_addr != '0;
  assign stay_tone = state_q == TONE && state_d == TONE;
  assign stay_gap  = state_q == GAP && state_d == GAP;

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q   <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      note_code <= '0;
      seq_addr  <= '0;
    end else begin
      state_q   <= state_d;
      busy      <= state_d != IDLE;
      done      <= done_d;
      note_code <= code_d;
      seq_addr  <= addr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (start) state_d = FETCH;
      FETCH: begin
        if (!is_end)     state_d = TONE;
        else if (!rewind) state_d = IDLE;
      end
      TONE:  if (tone_last) state_d = HAS_GAP ? GAP : FETCH;
      GAP:   if (gap_last) state_d = FETCH;
      default: state_d = IDLE;
    endcase
    if (stop) state_d = IDLE;
  end

  always_comb begin
    addr_d = seq_addr;
    code_d = '0;
    done_d = 1'b0;
    unique case (state_q)
      IDLE:  addr_d = '0;
      FETCH: begin
        if (!is_end) begin
          code_d = seq_data[7:5];
        end else begin
          addr_d = '0;
          done_d = !rewind;
        end
      end
      TONE: begin
        if (!tone_last)    code_d = note_code;
        else if (!HAS_GAP) addr_d = seq_addr + 1'b1;
      end
      GAP:   if (gap_last) addr_d = seq_addr + 1'b1;
      default: addr_d = '0;
    endcase
    if (stop) begin
      addr_d = '0;
      code_d = '0;
      done_d = 1'b0;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      presc_q <= '0;
      tone_q  <= '0;
      hp_q    <= '0;
      dur_q   <= '0;
      gap_q   <= '0;
      speaker <= 1'b0;
    end else begin
      if (stay_tone || stay_gap)
        presc_q <= tick_end ? '0 : presc_q + 1'b1;
      else
        presc_q <= '0;

      if (state_q == FETCH) begin
        dur_q <= seq_data[4:0];
        hp_q  <= half_period(seq_data[7:5]);
      end else if (state_q == TONE && tick_end) begin
        dur_q <= dur_q - 1'b1;
      end

      if (state_q == TONE)
        gap_q <= GAP_LOAD;
      else if (state_q == GAP && tick_end)
        gap_q <= gap_q - 1'b1;

      // a rest has hp_q of 0: the counter just wraps, speaker stays low
      if (stay_tone) begin
        tone_q <= half_end ? '0 : tone_q + 1'b1;
        if (half_end && hp_q != '0) speaker <= ~speaker;
      end else begin
        tone_q  <= '0;
        speaker <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_note_sequencer.sv
// Bench for note_sequencer: random play checked against a timeline model,
// plus directed literal checks on looping, stop, reset and tone timing.
module tb_note_sequencer;

  localparam int TD_A  = 3;
  localparam int GAP_A = 1;
  localparam int AW_A  = 2;
  localparam int TD_B  = 1600;
  localparam int GAP_B = 0;
  localparam int AW_B  = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, start_a, stop_a, loop_a;
  logic rst_b, start_b, stop_b, loop_b;
  logic [AW_A-1:0] addr_a;
  logic [AW_B-1:0] addr_b;
  logic [7:0] data_a, data_b;
  logic busy_a, done_a, spk_a;
  logic busy_b, done_b, spk_b;
  logic [2:0] note_a, note_b;
  logic [7:0] mem_a [4];
  logic [7:0] mem_b [32];

  assign data_a = mem_a[addr_a];
  assign data_b = mem_b[addr_b];

  note_sequencer #(.TICK_DIV(TD_A), .GAP_TICKS(GAP_A), .ADDR_W(AW_A)) u_a (
    .CLOCK_50(clk), .RESET_N(rst_a), .start(start_a), .stop(stop_a),
    .loop_en(loop_a), .seq_addr(addr_a), .seq_data(data_a),
    .busy(busy_a), .note_code(note_a), .done(done_a), .speaker(spk_a)
  );

  note_sequencer #(.TICK_DIV(TD_B), .GAP_TICKS(GAP_B), .ADDR_W(AW_B)) u_b (
    .CLOCK_50(clk), .RESET_N(rst_b), .start(start_b), .stop(stop_b),
    .loop_en(loop_b), .seq_addr(addr_b), .seq_data(data_b),
    .busy(busy_b), .note_code(note_b), .done(done_b), .speaker(spk_b)
  );

  int n_vec = 0;
  int n_err = 0;
  bit chk_on = 0;

  task automatic chk(input string nm, input int got, input int want);
    n_vec++;
    if (got != want) begin
      n_err++;
      $display("FAIL %s t=%0t got=%0d want=%0d", nm, $time, got, want);
    end
  endtask

  // timeline model: phase, cycles left in phase, cycles elapsed in tone
  typedef struct {
    int ph;
    int addr;
    int left;
    int el;
    int code;
    bit done;
  } mdl_t;

  mdl_t m;

  function automatic int hp(input int c);
    case (c)
      1: return 95556;
      2: return 85131;
      3: return 75843;
      4: return 71586;
      5: return 63776;
      6: return 56818;
      7: return 47778;
      default: return 0;
    endcase
  endfunction

  function automatic mdl_t mdl_rst();
    mdl_t r;
    r.ph = 0; r.addr = 0; r.left = 0;
    r.el = 0; r.code = 0; r.done = 0;
    return r;
  endfunction

  function automatic mdl_t step(input mdl_t c, input logic st,
                                input logic sp, input logic lp,
                                input logic [7:0] d);
    mdl_t n;
    n = c;
    n.done = 0;
    if (sp) begin
      n.ph = 0;
      n.addr = 0;
      return n;
    end
    case (c.ph)
      0: if (st) n.ph = 1;
      1: begin
        if (d[4:0] != 0) begin
          n.ph = 2;
          n.code = int'(d[7:5]);
          n.left = int'(d[4:0]) * TD_A;
          n.el = 0;
        end else if (lp && c.addr != 0) begin
          n.addr = 0;
        end else begin
          n.ph = 0;
          n.addr = 0;
          n.done = 1;
        end
      end
      2: begin
        n.el = c.el + 1;
        n.left = c.left - 1;
        if (n.left == 0) begin
          if (GAP_A > 0) begin
            n.ph = 3;
            n.left = GAP_A * TD_A;
          end else begin
            n.ph = 1;
            n.addr = (c.addr + 1) % (1 << AW_A);
          end
        end
      end
      default: begin
        n.left = c.left - 1;
        if (n.left == 0) begin
          n.ph = 1;
          n.addr = (c.addr + 1) % (1 << AW_A);
        end
      end
    endcase
    return n;
  endfunction

  function automatic int exp_spk(input mdl_t c);
    if (c.ph == 2 && c.code != 0)
      return (c.el / hp(c.code)) % 2;
    return 0;
  endfunction

  always @(posedge clk or negedge rst_a) begin
    if (!rst_a) m <= mdl_rst();
    else m <= step(m, start_a, stop_a, loop_a, mem_a[m.addr]);
  end

  always @(negedge clk) begin
    if (rst_a && chk_on) begin
      chk("busy", int'(busy_a), int'(m.ph != 0));
      chk("done", int'(done_a), int'(m.done));
      chk("code", int'(note_a), (m.ph == 2) ? m.code : 0);
      chk("addr", int'(addr_a), m.addr);
      chk("spk", int'(spk_a), exp_spk(m));
    end
  end

  task automatic pulse_start_a();
    start_a = 1;
    @(negedge clk);
    start_a = 0;
  endtask

  int n1, nd, nw, s5, prev, found;
  int t7, n7, rise, tog, spk_exit, dn, first1, nrest, nspk;
  logic spk_prev;

  initial begin
    rst_a = 0; rst_b = 0;
    start_a = 0; stop_a = 0; loop_a = 0;
    start_b = 0; stop_b = 0; loop_b = 0;
    for (int i = 0; i < 4; i++) mem_a[i] = '0;
    for (int i = 0; i < 32; i++) mem_b[i] = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", int'(busy_a), 0);
    chk("rst_addr", int'(addr_a), 0);
    chk("rst_spk", int'(spk_a), 0);
    chk("rst_code", int'(note_a), 0);
    rst_a = 1; rst_b = 1; chk_on = 1;
    @(negedge clk);
    chk("idle_busy", int'(busy_a), 0);
    chk("idle_done", int'(done_a), 0);

    // end marker at address 0 with looping enabled
    loop_a = 1;
    pulse_start_a();
    chk("m0_busy", int'(busy_a), 1);
    chk("m0_done_early", int'(done_a), 0);
    @(negedge clk);
    chk("m0_done", int'(done_a), 1);
    chk("m0_idle", int'(busy_a), 0);
    @(negedge clk);
    chk("m0_pulse", int'(done_a), 0);

    // loop {7,1},{0,0}: 8-cycle period, one cycle at addr 1
    mem_a[0] = {3'd7, 5'd1};
    pulse_start_a();
    n1 = 0; nd = 0;
    for (int k = 1; k <= 32; k++) begin
      if (addr_a == 1) n1++;
      if (done_a) nd++;
      @(negedge clk);
    end
    chk("loop_addr1", n1, 4);
    chk("loop_nodone", nd, 0);
    loop_a = 0;
    found = 0;
    for (int k = 0; k < 12 && found == 0; k++) begin
      @(negedge clk);
      if (done_a) found = k + 1;
    end
    chk("loop_end_done", found, 8);

    // start while busy, then stop mid-tone
    mem_a[0] = {3'd3, 5'd2};
    mem_a[1] = {3'd4, 5'd1};
    mem_a[2] = '0;
    pulse_start_a();
    @(negedge clk);
    @(negedge clk);
    start_a = 1;
    @(negedge clk);
    start_a = 0;
    chk("no_restart_code", int'(note_a), 3);
    chk("no_restart_busy", int'(busy_a), 1);
    stop_a = 1;
    @(negedge clk);
    stop_a = 0;
    chk("stop_busy", int'(busy_a), 0);
    chk("stop_spk", int'(spk_a), 0);
    chk("stop_addr", int'(addr_a), 0);
    chk("stop_code", int'(note_a), 0);
    nd = int'(done_a);
    repeat (5) begin
      @(negedge clk);
      if (done_a) nd++;
    end
    chk("stop_nodone", nd, 0);

    // start and stop together in IDLE
    start_a = 1; stop_a = 1;
    @(negedge clk);
    start_a = 0; stop_a = 0;
    chk("ss_busy", int'(busy_a), 0);
    @(negedge clk);
    chk("ss_busy2", int'(busy_a), 0);

    // async reset mid-gap
    for (int i = 0; i < 4; i++) mem_a[i] = {3'd5, 5'd1};
    pulse_start_a();
    repeat (5) @(negedge clk);
    chk("gap_busy", int'(busy_a), 1);
    chk("gap_code", int'(note_a), 0);
    #2 rst_a = 0;
    #1;
    chk("arst_busy", int'(busy_a), 0);
    chk("arst_addr", int'(addr_a), 0);
    chk("arst_code", int'(note_a), 0);
    chk("arst_spk", int'(spk_a), 0);
    chk("arst_done", int'(done_a), 0);
    @(negedge clk);
    rst_a = 1;
    @(negedge clk);
    chk("arst_idle", int'(busy_a), 0);

    // address wrap 3 -> 0 keeps playing
    pulse_start_a();
    prev = 0; nw = 0; s5 = 0; nd = 0;
    for (int k = 1; k <= 35; k++) begin
      if (busy_a && prev == 3 && addr_a == 0) nw++;
      if (nw > 0 && note_a == 5) s5 = 1;
      if (done_a) nd++;
      prev = int'(addr_a);
      @(negedge clk);
    end
    chk("wrap_cnt", nw, 1);
    chk("wrap_cont", s5, 1);
    chk("wrap_nodone", nd, 0);

    // randomized play against the model
    for (int r = 0; r < 30; r++) begin
      stop_a = 1;
      @(negedge clk);
      stop_a = 0;
      for (int i = 0; i < 4; i++) begin
        mem_a[i][7:5] = 3'($urandom_range(0, 7));
        mem_a[i][4:0] = ($urandom_range(0, 3) == 0) ? 5'd0
                        : 5'($urandom_range(1, 4));
      end
      loop_a = 1'($urandom_range(0, 1));
      pulse_start_a();
      for (int c = 0; c < 150; c++) begin
        start_a = ($urandom_range(0, 9) == 0);
        stop_a  = ($urandom_range(0, 79) == 0);
        if ($urandom_range(0, 19) == 0) loop_a = ~loop_a;
        @(negedge clk);
      end
      start_a = 0; stop_a = 0;
    end

    // long C5 note: one rise at 47778 cycles into the tone
    mem_b[0] = {3'd7, 5'd31};
    mem_b[1] = '0;
    start_b = 1;
    @(negedge clk);
    start_b = 0;
    t7 = 0; n7 = 0; rise = 0; tog = 0; spk_exit = -1; dn = 0;
    spk_prev = 0;
    for (int k = 1; k <= 49610; k++) begin
      if (note_b == 7) begin
        n7++;
        if (t7 == 0) t7 = k;
        if (spk_b != spk_prev) tog++;
        if (spk_b && !spk_prev && rise == 0) rise = k;
      end
      if (k == 49602) spk_exit = int'(spk_b);
      if (done_b && dn == 0) dn = k;
      spk_prev = spk_b;
      @(negedge clk);
    end
    chk("c5_entry", t7, 2);
    chk("c5_len", n7, 49600);
    chk("c5_rise", rise - t7, 47778);
    chk("c5_toggles", tog, 1);
    chk("c5_exit_spk", spk_exit, 0);
    chk("c5_done", dn, 49603);

    // rest then short C4, gapless
    mem_b[0] = {3'd0, 5'd3};
    mem_b[1] = {3'd1, 5'd1};
    mem_b[2] = '0;
    start_b = 1;
    @(negedge clk);
    start_b = 0;
    first1 = 0; n1 = 0; nrest = 0; nspk = 0; dn = 0;
    for (int k = 1; k <= 6410; k++) begin
      if (note_b == 1) begin
        n1++;
        if (first1 == 0) first1 = k;
      end
      if (k >= 2 && k <= 4801 && busy_b && note_b == 0) nrest++;
      if (spk_b) nspk++;
      if (done_b && dn == 0) dn = k;
      @(negedge clk);
    end
    chk("rest_len", nrest, 4800);
    chk("c4_entry", first1, 4803);
    chk("c4_len", n1, 1600);
    chk("c4_silent", nspk, 0);
    chk("gapless_done", dn, 6404);
    chk("gapless_idle", int'(busy_b), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
